mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port to one-port memory arbiter for the multicycle RV32I core. Shares a single physical memory port between the instruction-fetch requester (I-side) and the load/store requester (D-side). Each request uses the same level read/write + `resp` handshake as the memory. Grants one transaction at a time, holds the grant until the memory responds, and routes read data and response back to the granted side only.

## Interface
- `STARVE_LIMIT`, default 4: consecutive D-side grants allowed while I-side waits before I-side is forced next (fixed-priority mode only).
- `clk` input 1: clock, rising-edge.
- `rst` input 1: asynchronous, active-low reset.
- `i_read` input 1: I-side read request, level, held until `i_resp`.
- `i_address` input 32: I-side byte address.
- `i_rdata` output 32: I-side read data, valid when `i_resp`=1.
- `i_resp` output 1: I-side transaction complete.
- `d_read` input 1: D-side read request, level, held until `d_resp`.
- `d_write` input 1: D-side write request, level, held until `d_resp`.
- `d_address` input 32: D-side byte address.
- `d_wdata` input 32: D-side write data.
- `d_byte_enable` input 4: D-side byte lanes.
- `d_rdata` output 32: D-side read data, valid when `d_resp`=1.
- `d_resp` output 1: D-side transaction complete.
- `mem_read` output 1: memory read strobe.
- `mem_write` output 1: memory write strobe.
- `mem_address` output 32: memory address.
- `mem_wdata` output 32: memory write data.
- `mem_byte_enable` output 4: memory byte lanes.
- `mem_rdata` input 32: memory read data.
- `mem_resp` input 1: memory completion, one cycle per transaction.

## Operation
- States: IDLE, I_BUSY, D_BUSY.
- IDLE:
  - No requests: stay.
  - Only I pending: go to I_BUSY.
  - Only D pending: go to D_BUSY.
  - Both pending: use the pick rule (see Configuration).
- On the grant edge, latch address, wdata, byte_enable and op (read/write) into holding registers. Memory outputs are driven only from these registers, so requester changes during BUSY are ignored.
- I_BUSY: `mem_read`=1, `mem_byte_enable`=4'b1111. On `mem_resp`: `i_resp`=1 and `i_rdata`=`mem_rdata` combinationally, same cycle; next state IDLE.
- D_BUSY: `mem_read` or `mem_write` per the latched op. On `mem_resp`: `d_resp`=1 and `d_rdata`=`mem_rdata`, same cycle; next state IDLE.
- `d_read` and `d_write` both high at grant: treated as a write.
- The non-granted side never sees `resp`. Its `rdata` outputs 0.
- Starvation counter `starve_cnt`, width clog2(STARVE_LIMIT+1):
  - Increments on each D grant taken while `i_read`=1.
  - Clears on any I grant.
  - Saturates at STARVE_LIMIT.
- `mem_resp` in IDLE is ignored; no output responds to it.

## Timing
- Reset: state IDLE; `mem_read`, `mem_write`, `i_resp`, `d_resp`=0; `mem_address`, `mem_wdata`=0; `mem_byte_enable`=4'b0000; `starve_cnt`=0; round-robin pointer=I.
- Request asserted in cycle N while IDLE → memory strobe asserted in cycle N+1.
- `resp` is combinational with `mem_resp`. The BUSY→IDLE edge follows `mem_resp`, giving at least one IDLE cycle between transactions.
- A request that is still high in the IDLE cycle after its own `resp` is treated as a new request. Requesters must deassert in that cycle, as the control FSM does on leaving its wait state.
- Reset asserted mid-transaction: strobes drop immediately (asynchronous) and the transaction is abandoned.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined:
  - Both pending in IDLE → grant the side opposite the last granted side.
  - The pointer updates on every grant.
  - `starve_cnt` and STARVE_LIMIT are unused; the counter is tied to 0.
- Undefined:
  - Fixed priority, D over I.
  - Exception: I is granted when `starve_cnt`==STARVE_LIMIT.

## Structure
- Package `arb_types`: enum `arb_state_t` {IDLE, I_BUSY, D_BUSY}; enum `arb_side_t` {SIDE_I, SIDE_D}.
- Sub-module `arb_pick`: pick logic plus round-robin pointer / starvation counter.
  - Inputs: `i_read`, `d_read|d_write`, grant strobe.
  - Output: the chosen `arb_side_t`.
- Everything else (FSM, holding registers, output mux) lives in `mem_arbiter`.

## Test plan
- I-only: `i_read`=1, `i_address`=0x60, memory responds after 3 cycles with 0x00A00093.
  - `mem_read`=1 with `mem_address`=0x60 from cycle 1.
  - `i_resp`=1 with `i_rdata`=0x00A00093 in the `mem_resp` cycle.
  - `d_resp` stays 0.
- D write: `d_write`=1, addr 0x100, wdata 0xDEADBEEF, be 4'b0011.
  - `mem_write`=1 with those exact values.
  - Changing `d_address` mid-transaction does not change `mem_address`.
- Both assert together, fixed mode: D granted first; I granted in the next IDLE cycle.
  - Round-robin mode, last grant I: D granted.
  - Round-robin mode, last grant D: I granted.
- Starvation, fixed mode, STARVE_LIMIT=4: `i_read` held, D re-requests back-to-back → exactly 4 D grants, then I is granted.
- Asynchronous reset low during D_BUSY → `mem_write`=0 within the same cycle, state IDLE, all outputs at reset values.
- Stray `mem_resp`=1 in IDLE → `i_resp` and `d_resp` remain 0 and state is unchanged.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the I/D memory arbiter: FSM states and requester sides.
package arb_types;

    typedef enum logic [1:0] {
        IDLE,
        I_BUSY,
        D_BUSY
    } arb_state_t;

    typedef enum logic {
        SIDE_I,
        SIDE_D
    } arb_side_t;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Requester selection for mem_arbiter: fixed D-over-I priority with an I-side
// starvation escape, or round-robin when MEM_ARB_ROUND_ROBIN_EN is defined.
module arb_pick
    import arb_types::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_req,
    input  logic      d_req,
    input  logic      grant,
    output arb_side_t side
);

    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] starve_cnt;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    arb_side_t last;

    assign starve_cnt = '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last <= SIDE_I;
        end else if (grant) begin
            last <= side;
        end
    end

    always_comb begin
        side = SIDE_D;
        if (i_req && d_req) begin
            side = (last == SIDE_I) ? SIDE_D : SIDE_I;
        end else if (i_req) begin
            side = SIDE_I;
        end
    end
`else
    localparam logic [CW-1:0] LIMIT = STARVE_LIMIT[CW-1:0];

    // Counts D grants taken while I was left waiting; any I grant resets it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (grant) begin
            if (side == SIDE_I) begin
                starve_cnt <= '0;
            end else if (i_req && (starve_cnt != LIMIT)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        side = SIDE_D;
        if (i_req && d_req) begin
            side = (starve_cnt == LIMIT) ? SIDE_I : SIDE_D;
        end else if (i_req) begin
            side = SIDE_I;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port to one-port memory arbiter (I-fetch vs load/store).
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration instead of fixed priority.
module mem_arbiter
    import arb_types::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_read,
    input  logic [31:0] i_address,
    output logic [31:0] i_rdata,
    output logic        i_resp,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_address,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_byte_enable,
    output logic [31:0] d_rdata,
    output logic        d_resp,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp
);

    arb_state_t  state, state_next;
    arb_side_t   pick;
    logic        d_req;
    logic        grant;
    logic [31:0] hold_addr;
    logic [31:0] hold_wdata;
    logic [3:0]  hold_be;
    logic        hold_write;

    assign d_req = d_read | d_write;
    assign grant = (state == IDLE) && (i_read || d_req);

    arb_pick #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_pick (
        .clk  (clk),
        .rst  (rst),
        .i_req(i_read),
        .d_req(d_req),
        .grant(grant),
        .side (pick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_next = (pick == SIDE_I) ? I_BUSY : D_BUSY;
                end
            end
            I_BUSY, D_BUSY: begin
                if (mem_resp) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Memory side is driven only from these, so requester changes mid-transaction are invisible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_addr  <= '0;
            hold_wdata <= '0;
            hold_be    <= '0;
            hold_write <= 1'b0;
        end else if (grant) begin
            if (pick == SIDE_I) begin
                hold_addr  <= i_address;
                hold_wdata <= '0;
                hold_be    <= '1;
                hold_write <= 1'b0;
            end else begin
                hold_addr  <= d_address;
                hold_wdata <= d_wdata;
                hold_be    <= d_byte_enable;
                hold_write <= d_write;
            end
        end
    end

    always_comb begin
        mem_read        = (state == I_BUSY) || ((state == D_BUSY) && !hold_write);
        mem_write       = (state == D_BUSY) && hold_write;
        mem_address     = hold_addr;
        mem_wdata       = hold_wdata;
        mem_byte_enable = hold_be;
        i_resp          = (state == I_BUSY) && mem_resp;
        d_resp          = (state == D_BUSY) && mem_resp;
        i_rdata         = i_resp ? mem_rdata : '0;
        d_rdata         = d_resp ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, directed corner sequences,
// and randomized transactions checked against a transaction-level model.
module tb_mem_arbiter;

    localparam int unsigned STARVE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_read;
    logic [31:0] i_address;
    logic [31:0] i_rdata;
    logic        i_resp;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_address;
    logic [31:0] d_wdata;
    logic [3:0]  d_byte_enable;
    logic [31:0] d_rdata;
    logic        d_resp;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    always #5 clk = ~clk;

    mem_arbiter #(
        .STARVE_LIMIT(STARVE)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_read         (i_read),
        .i_address      (i_address),
        .i_rdata        (i_rdata),
        .i_resp         (i_resp),
        .d_read         (d_read),
        .d_write        (d_write),
        .d_address      (d_address),
        .d_wdata        (d_wdata),
        .d_byte_enable  (d_byte_enable),
        .d_rdata        (d_rdata),
        .d_resp         (d_resp),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_byte_enable(mem_byte_enable),
        .mem_rdata      (mem_rdata),
        .mem_resp       (mem_resp)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state: side 0 = I, 1 = D.
    int m_last;
    int m_starve;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int m_pick(input bit i, input bit d);
        if (i && !d) return 0;
        if (d && !i) return 1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        return 1 - m_last;
`else
        return (m_starve >= int'(STARVE)) ? 0 : 1;
`endif
    endfunction

    function automatic void m_grant(input int side, input bit i_pending);
        m_last = side;
        if (side == 0) m_starve = 0;
        else if (i_pending && m_starve < int'(STARVE)) m_starve++;
    endfunction

    task automatic m_reset();
        m_last   = 0;
        m_starve = 0;
    endtask

    task automatic set_req(input bit ir, input bit dr, input bit dw, input logic [31:0] ia,
                           input logic [31:0] da, input logic [31:0] wd, input logic [3:0] be);
        i_read = ir; d_read = dr; d_write = dw;
        i_address = ia; d_address = da; d_wdata = wd; d_byte_enable = be;
    endtask

    // Called at posedge+1 of an IDLE cycle with requests already driven.
    task automatic do_txn(input int side, input int lat, input logic [31:0] rdata,
                          input bit drop, input string tag);
        logic [31:0] ea, ew;
        logic [3:0]  eb;
        bit          ewr;
        #2;
        chk({tag, " idle_strobes"}, {30'd0, mem_read, mem_write}, 32'd0);
        if (side == 0) begin
            ea = i_address; ew = 32'd0; eb = 4'hF; ewr = 1'b0;
        end else begin
            ea = d_address; ew = d_wdata; eb = d_byte_enable; ewr = d_write;
        end
        m_grant(side, i_read);
        tick();
        for (int c = 0; c < lat; c++) begin
            if (c == lat - 1) begin
                mem_resp  = 1'b1;
                mem_rdata = rdata;
            end
            #2;
            chk({tag, " mem_read"}, {31'd0, mem_read}, {31'd0, !ewr});
            chk({tag, " mem_write"}, {31'd0, mem_write}, {31'd0, ewr});
            chk({tag, " mem_address"}, mem_address, ea);
            chk({tag, " mem_be"}, {28'd0, mem_byte_enable}, {28'd0, eb});
            if (ewr) chk({tag, " mem_wdata"}, mem_wdata, ew);
            if (c < lat - 1) begin
                chk({tag, " early_resp"}, {30'd0, i_resp, d_resp}, 32'd0);
                i_address = $urandom; d_address = $urandom;
                d_wdata = $urandom; d_byte_enable = 4'($urandom);
            end else begin
                chk({tag, " i_resp"}, {31'd0, i_resp}, {31'd0, side == 0});
                chk({tag, " d_resp"}, {31'd0, d_resp}, {31'd0, side == 1});
                chk({tag, " i_rdata"}, i_rdata, (side == 0) ? rdata : 32'd0);
                chk({tag, " d_rdata"}, d_rdata, (side == 1) ? rdata : 32'd0);
            end
            tick();
        end
        mem_resp = 1'b0;
        if (drop) begin
            if (side == 0) i_read = 1'b0;
            else begin d_read = 1'b0; d_write = 1'b0; end
        end
    endtask

    typedef struct {
        bit          i_rd, d_rd, d_wr;
        logic [31:0] ia, da, wd;
        logic [3:0]  be;
        int          lat;
        logic [31:0] rdata;
        int          exp_side;
    } vec_t;

    vec_t vt[5];

    initial begin
        int s;
        int s2;
        mem_resp = 1'b0; mem_rdata = 32'hFFFF_FFFF;
        set_req(0, 0, 0, 0, 0, 0, 0);
        m_reset();
        rst = 1'b0;
        tick(); tick();
        #2;
        chk("reset strobes", {30'd0, mem_read, mem_write}, 32'd0);
        chk("reset resps", {30'd0, i_resp, d_resp}, 32'd0);
        chk("reset mem_address", mem_address, 32'd0);
        chk("reset mem_wdata", mem_wdata, 32'd0);
        chk("reset mem_be", {28'd0, mem_byte_enable}, 32'd0);
        tick();
        rst = 1'b1;
        tick();

        vt[0] = '{1, 0, 0, 32'h60,  32'h0,   32'h0,        4'h0, 3, 32'h00A00093, 0};
        vt[1] = '{0, 0, 1, 32'h0,   32'h100, 32'hDEADBEEF, 4'h3, 3, 32'h0,        1};
        vt[2] = '{0, 1, 0, 32'h0,   32'h204, 32'h0,        4'hF, 1, 32'h12345678, 1};
        vt[3] = '{0, 1, 1, 32'h0,   32'h208, 32'hCAFEF00D, 4'hC, 2, 32'h0,        1};
        vt[4] = '{1, 0, 0, 32'h64,  32'h0,   32'h0,        4'h0, 1, 32'h00B00113, 0};
        for (int k = 0; k < 5; k++) begin
            set_req(vt[k].i_rd, vt[k].d_rd, vt[k].d_wr, vt[k].ia, vt[k].da, vt[k].wd, vt[k].be);
            do_txn(vt[k].exp_side, vt[k].lat, vt[k].rdata, 1, $sformatf("vec%0d", k));
        end

        // Both pending with last grant I, then with last grant D.
        set_req(1, 1, 0, 32'h80, 32'h300, 32'h0, 4'hF);
        s = m_pick(1, 1);
        do_txn(s, 2, 32'hA5A5_0001, 1, "both_a1");
        s2 = m_pick(i_read, d_read | d_write);
        do_txn(s2, 2, 32'hA5A5_0002, 1, "both_a2");
        set_req(0, 1, 0, 32'h0, 32'h310, 32'h0, 4'hF);
        do_txn(1, 1, 32'h5A5A_0003, 1, "d_only");
        set_req(1, 1, 0, 32'h84, 32'h314, 32'h0, 4'hF);
        s = m_pick(1, 1);
        do_txn(s, 1, 32'h5A5A_0004, 1, "both_b1");
        s2 = m_pick(i_read, d_read | d_write);
        do_txn(s2, 1, 32'h5A5A_0005, 1, "both_b2");

        // Starvation: both held continuously, D re-requesting back-to-back.
        set_req(1, 0, 1, 32'h90, 32'h400, 32'h1111_2222, 4'hF);
        for (int k = 0; k < int'(STARVE) + 1; k++) begin
            s = m_pick(i_read, d_read | d_write);
            do_txn(s, 1, 32'h0, 0, $sformatf("starve%0d", k));
        end
        set_req(0, 0, 0, 0, 0, 0, 0);
        tick();

        // Stray mem_resp while idle.
        mem_resp = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        #2;
        chk("stray resps", {30'd0, i_resp, d_resp}, 32'd0);
        chk("stray strobes", {30'd0, mem_read, mem_write}, 32'd0);
        tick();
        mem_resp = 1'b0;
        #2;
        chk("stray after strobes", {30'd0, mem_read, mem_write}, 32'd0);
        tick();
        set_req(0, 1, 0, 32'h0, 32'h500, 32'h0, 4'h1);
        do_txn(1, 2, 32'h0000_0042, 1, "post_stray");

        // Asynchronous reset during a D write.
        set_req(0, 0, 1, 32'h0, 32'h600, 32'h7777_8888, 4'hF);
        tick();
        #2;
        chk("rst_pre mem_write", {31'd0, mem_write}, 32'd1);
        rst = 1'b0;
        #1;
        chk("rst_mid strobes", {30'd0, mem_read, mem_write}, 32'd0);
        chk("rst_mid mem_address", mem_address, 32'd0);
        chk("rst_mid mem_wdata", mem_wdata, 32'd0);
        chk("rst_mid mem_be", {28'd0, mem_byte_enable}, 32'd0);
        chk("rst_mid resps", {30'd0, i_resp, d_resp}, 32'd0);
        set_req(0, 0, 0, 0, 0, 0, 0);
        m_reset();
        tick();
        rst = 1'b1;
        tick();
        set_req(1, 0, 0, 32'h700, 32'h0, 32'h0, 4'h0);
        do_txn(0, 1, 32'h0000_0013, 1, "post_rst");

        // Randomized transactions against the model.
        for (int k = 0; k < 40; k++) begin
            bit ir, dr, dw;
            ir = 1'($urandom); dr = 1'($urandom); dw = 1'($urandom);
            if (!ir && !dr && !dw) ir = 1'b1;
            set_req(ir, dr, dw, $urandom, $urandom, $urandom, 4'($urandom));
            s = m_pick(i_read, d_read | d_write);
            do_txn(s, int'($urandom_range(1, 4)), $urandom, 1, $sformatf("rnd%0d", k));
            if (i_read || d_read || d_write) begin
                s2 = m_pick(i_read, d_read | d_write);
                do_txn(s2, int'($urandom_range(1, 4)), $urandom, 1, $sformatf("rnd%0db", k));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
